arp_cache_resolver: RTL and testbench
=====================================

Name: arp_cache_resolver

Overview:
- Resolves next-hop IPv4 addresses to MAC addresses for the IP transmit path.
- Serves the ARP request/response handshake issued by the IP block (arp_request_* / arp_response_*). Answers from a small fully-associative cache.
- The cache is filled by the ARP receive logic through a write port. A miss returns an error, and the IP block drops the packet.
- Applies subnet routing: broadcast addresses resolve to the broadcast MAC, and off-subnet addresses resolve via the gateway.

Parameters:
CACHE_ENTRIES, 8, number of cache entries (power of two, 2..64)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arp_request_valid  in  1  lookup request valid
arp_request_ready  out  1  lookup request accepted
arp_request_ip  in  32  IPv4 address to resolve
arp_response_valid  out  1  lookup result valid
arp_response_ready  in  1  result consumed
arp_response_error  out  1  resolution failed (miss or no gateway)
arp_response_mac  out  48  resolved MAC (0 when error)
cache_write_valid  in  1  learn/update entry (always accepted)
cache_write_ip  in  32  IP to store
cache_write_mac  in  48  MAC to store
cache_clear  in  1  invalidate all entries
local_ip  in  32  our IP
gateway_ip  in  32  default gateway (0 = none)
subnet_mask  in  32  subnet mask

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values:
  - state IDLE; arp_request_ready=1; arp_response_valid=0; arp_response_error=0; arp_response_mac=0.
  - All entry valid bits 0; replacement pointer 0.
  - Entry IP/MAC storage is not reset.
- States are IDLE, LOOKUP and RESPOND.
- IDLE:
  - arp_request_ready=1.
  - On valid&&ready at edge T: capture the next-hop IP, deassert ready, go to LOOKUP.
- Next-hop selection, computed in IDLE from arp_request_ip and the config inputs at the accept edge:
  - Broadcast: ip==32'hFFFFFFFF or ip==(local_ip|~subnet_mask). Sets a broadcast flag.
  - Local: (ip&subnet_mask)==(local_ip&subnet_mask). Next hop = ip.
  - Otherwise: next hop = gateway_ip. If gateway_ip==0, set a no-route flag.
- LOOKUP, one cycle:
  - Compare the next hop against all valid entries in parallel.
  - Broadcast flag: mac=48'hFFFFFFFFFFFF, error=0.
  - No-route flag: error=1, mac=0.
  - Hit: mac=entry MAC, error=0.
  - Miss: error=1, mac=0.
  - Multiple hits cannot occur (writes update in place); if they do, the lowest index wins.
  - Register the result and go to RESPOND.
- RESPOND:
  - arp_response_valid=1, with mac and error held stable.
  - On valid&&ready: drop valid, restore ready=1, go to IDLE.
- Latency: request accepted at edge T; response_valid high from T+2. With ready held high, the next request is accepted at T+3.
- Write port:
  - cache_write_valid is sampled every cycle in every state.
  - If cache_write_ip matches a valid entry: overwrite that entry's MAC.
  - Otherwise: write entry[ptr], set its valid bit, ptr=(ptr+1) mod CACHE_ENTRIES.
  - A write with cache_write_ip==0 is ignored.
- Simultaneous write and LOOKUP: the comparison uses pre-edge table contents. A write landing in the same cycle is visible only to the next request.
- cache_clear:
  - Clears all valid bits and sets ptr=0.
  - Takes priority over a same-cycle write; that write is discarded.
  - Does not abort LOOKUP or RESPOND. A LOOKUP in the clear cycle still compares pre-edge contents.
- Table full: the round-robin pointer overwrites the oldest-inserted entry. In-place updates do not advance ptr.
- Reset during LOOKUP/RESPOND: the response is dropped with no valid pulse; returns to IDLE with ready=1 the next cycle.

Test Plan:
- Learn, then hit:
  - Stimulus: local_ip=192.168.1.128, mask=FFFFFF00; write 192.168.1.102 -> 5A:51:52:53:54:55; request 192.168.1.102.
  - Required: valid at T+2, mac=5A5152535455, error=0.
- Broadcast and miss:
  - Request 255.255.255.255 and 192.168.1.255 -> mac=FFFFFFFFFFFF, error=0.
  - Request 192.168.1.7 with empty cache -> error=1, mac=0.
- Gateway routing:
  - gateway=192.168.1.1, cached as 02:00:00:00:00:01; request 8.8.8.8 -> mac=020000000001.
  - With gateway=0 -> error=1.
- Replacement and update:
  - Write 9 distinct IPs with CACHE_ENTRIES=8 -> the first IP misses and the 9th hits.
  - Rewrite IP #5 with a new MAC -> new MAC returned, ptr unchanged (the next new IP lands in entry 1).
- Backpressure and collisions:
  - arp_response_ready held low 5 cycles -> valid/mac stable; request_ready=0 throughout.
  - Write during LOOKUP of the same IP -> miss; the immediately following request hits.
- Clear and reset:
  - cache_clear with a same-cycle write -> all subsequent requests miss.
  - rst asserted in RESPOND -> response_valid=0 next cycle, request_ready=1.

Source files
------------

// File: rtl/arp_cache_resolver.sv
// Next-hop MAC resolver for the IP transmit path: applies subnet/broadcast/gateway routing,
// then looks the next hop up in a small fully-associative cache filled by ARP receive.
`timescale 1ns/1ps

module arp_cache_resolver #(
    parameter int unsigned CACHE_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,

    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,

    input  logic        cache_write_valid,
    input  logic [31:0] cache_write_ip,
    input  logic [47:0] cache_write_mac,
    input  logic        cache_clear,

    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    localparam int unsigned PtrW = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StRespond} state_e;

    state_e state_q, state_d;

    logic [31:0] nh_ip_q, nh_ip_d;
    logic        bcast_q, bcast_d;
    logic        noroute_q, noroute_d;
    logic [47:0] resp_mac_q, resp_mac_d;
    logic        resp_err_q, resp_err_d;

    logic [CACHE_ENTRIES-1:0] valid_q, valid_d;
    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [31:0]              ip_q  [CACHE_ENTRIES];
    logic [47:0]              mac_q [CACHE_ENTRIES];

    logic        req_fire;
    logic        is_bcast, is_local, noroute_sel;
    logic [31:0] nh_sel;
    logic        lk_hit;
    logic [47:0] lk_mac;
    logic        wr_en, wr_hit;
    logic [PtrW-1:0] wr_idx, wr_slot;

    assign req_fire = arp_request_valid && (state_q == StIdle);

    // Routing decision on the raw request address and current configuration.
    always_comb begin
        is_bcast    = (arp_request_ip == 32'hFFFF_FFFF) ||
                      (arp_request_ip == (local_ip | ~subnet_mask));
        is_local    = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
        nh_sel      = is_local ? arp_request_ip : gateway_ip;
        noroute_sel = !is_bcast && !is_local && (gateway_ip == 32'h0);
    end

    // Parallel lookup; iterating downward lets the lowest matching index win.
    always_comb begin
        lk_hit = 1'b0;
        lk_mac = '0;
        for (int i = int'(CACHE_ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == nh_ip_q)) begin
                lk_hit = 1'b1;
                lk_mac = mac_q[i];
            end
        end
    end

    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = int'(CACHE_ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == cache_write_ip)) begin
                wr_hit = 1'b1;
                wr_idx = PtrW'(i);
            end
        end
    end

    assign wr_en   = cache_write_valid && (cache_write_ip != 32'h0) && !cache_clear;
    assign wr_slot = wr_hit ? wr_idx : ptr_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_fire) state_d = StLookup;
            StLookup:  state_d = StRespond;
            StRespond: if (arp_response_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        arp_request_ready  = (state_q == StIdle);
        arp_response_valid = (state_q == StRespond);
        arp_response_error = resp_err_q;
        arp_response_mac   = resp_mac_q;
    end

    always_comb begin
        nh_ip_d    = nh_ip_q;
        bcast_d    = bcast_q;
        noroute_d  = noroute_q;
        resp_mac_d = resp_mac_q;
        resp_err_d = resp_err_q;

        if (req_fire) begin
            nh_ip_d   = nh_sel;
            bcast_d   = is_bcast;
            noroute_d = noroute_sel;
        end

        if (state_q == StLookup) begin
            if (bcast_q) begin
                resp_mac_d = 48'hFFFF_FFFF_FFFF;
                resp_err_d = 1'b0;
            end else if (noroute_q || !lk_hit) begin
                resp_mac_d = '0;
                resp_err_d = 1'b1;
            end else begin
                resp_mac_d = lk_mac;
                resp_err_d = 1'b0;
            end
        end
    end

    // In-place updates leave the round-robin pointer alone.
    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (cache_clear) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (wr_en && !wr_hit) begin
            valid_d[ptr_q] = 1'b1;
            ptr_d          = ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nh_ip_q    <= '0;
            bcast_q    <= 1'b0;
            noroute_q  <= 1'b0;
            resp_mac_q <= '0;
            resp_err_q <= 1'b0;
            valid_q    <= '0;
            ptr_q      <= '0;
        end else begin
            nh_ip_q    <= nh_ip_d;
            bcast_q    <= bcast_d;
            noroute_q  <= noroute_d;
            resp_mac_q <= resp_mac_d;
            resp_err_q <= resp_err_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
        end
    end

    // Entry storage is not reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ip_q[wr_slot]  <= cache_write_ip;
            mac_q[wr_slot] <= cache_write_mac;
        end
    end

endmodule

// File: tb/tb_arp_cache_resolver.sv
// Directed plus randomized bench for arp_cache_resolver, checked against an ip->mac map with
// oldest-first eviction.
`timescale 1ns/1ps

module tb_arp_cache_resolver;

    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_request_valid;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip;
    logic        arp_response_valid;
    logic        arp_response_ready;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_write_valid;
    logic [31:0] cache_write_ip;
    logic [47:0] cache_write_mac;
    logic        cache_clear;
    logic [31:0] local_ip;
    logic [31:0] gateway_ip;
    logic [31:0] subnet_mask;

    always #5 clk = ~clk;

    arp_cache_resolver #(.CACHE_ENTRIES(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .arp_request_valid  (arp_request_valid),
        .arp_request_ready  (arp_request_ready),
        .arp_request_ip     (arp_request_ip),
        .arp_response_valid (arp_response_valid),
        .arp_response_ready (arp_response_ready),
        .arp_response_error (arp_response_error),
        .arp_response_mac   (arp_response_mac),
        .cache_write_valid  (cache_write_valid),
        .cache_write_ip     (cache_write_ip),
        .cache_write_mac    (cache_write_mac),
        .cache_clear        (cache_clear),
        .local_ip           (local_ip),
        .gateway_ip         (gateway_ip),
        .subnet_mask        (subnet_mask)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: learned addresses plus their insertion order (oldest first).
    logic [47:0] m_mac [logic [31:0]];
    logic [31:0] m_order [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [31:0] ip, input logic [47:0] mac);
        if (ip == 32'h0) return;
        if (!m_mac.exists(ip)) begin
            if (m_order.size() == N) m_mac.delete(m_order.pop_front());
            m_order.push_back(ip);
        end
        m_mac[ip] = mac;
    endfunction

    function automatic void model_clear();
        m_mac.delete();
        m_order.delete();
    endfunction

    // Returns {error, mac}.
    function automatic logic [48:0] model_resolve(input logic [31:0] ip);
        logic [31:0] nh;
        if (ip == 32'hFFFF_FFFF || ip == (local_ip | ~subnet_mask))
            return {1'b0, 48'hFFFF_FFFF_FFFF};
        if ((ip & subnet_mask) == (local_ip & subnet_mask)) nh = ip;
        else if (gateway_ip == 32'h0) return {1'b1, 48'h0};
        else nh = gateway_ip;
        if (m_mac.exists(nh)) return {1'b0, m_mac[nh]};
        return {1'b1, 48'h0};
    endfunction

    task automatic do_write(input logic [31:0] ip, input logic [47:0] mac);
        @(negedge clk);
        cache_write_valid = 1'b1;
        cache_write_ip    = ip;
        cache_write_mac   = mac;
        @(posedge clk); #1;
        cache_write_valid = 1'b0;
        model_write(ip, mac);
    endtask

    task automatic do_clear(input bit with_write, input logic [31:0] ip);
        @(negedge clk);
        cache_clear       = 1'b1;
        cache_write_valid = with_write;
        cache_write_ip    = ip;
        cache_write_mac   = 48'h1234_5678_9ABC;
        @(posedge clk); #1;
        cache_clear       = 1'b0;
        cache_write_valid = 1'b0;
        model_clear();
    endtask

    // Optional write (cw) lands in the LOOKUP cycle; it must not affect this response.
    task automatic do_request(input logic [31:0] ip, input int hold, input bit cw,
                              input logic [31:0] cw_ip, input logic [47:0] cw_mac);
        logic [48:0] exp;
        @(negedge clk);
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        check("req_ready_idle", 64'(arp_request_ready), 64'd1);
        exp = model_resolve(ip);
        @(posedge clk); #1;
        arp_request_valid = 1'b0;
        check("lookup_no_valid", 64'(arp_response_valid), 64'd0);
        if (cw) begin
            cache_write_valid = 1'b1;
            cache_write_ip    = cw_ip;
            cache_write_mac   = cw_mac;
        end
        @(posedge clk); #1;
        if (cw) begin
            cache_write_valid = 1'b0;
            model_write(cw_ip, cw_mac);
        end
        check("resp_valid", 64'(arp_response_valid), 64'd1);
        check("resp_error", 64'(arp_response_error), 64'(exp[48]));
        check("resp_mac", 64'(arp_response_mac), 64'(exp[47:0]));
        check("req_ready_busy", 64'(arp_request_ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(arp_response_valid), 64'd1);
            check("hold_mac", 64'(arp_response_mac), 64'(exp[47:0]));
            check("hold_error", 64'(arp_response_error), 64'(exp[48]));
            check("hold_req_ready", 64'(arp_request_ready), 64'd0);
        end
        arp_response_ready = 1'b1;
        @(posedge clk); #1;
        arp_response_ready = 1'b0;
        check("resp_drop", 64'(arp_response_valid), 64'd0);
        check("ready_back", 64'(arp_request_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ip;
        logic [63:0] r64;
        int          op;

        rst                = 1'b1;
        arp_request_valid  = 1'b0;
        arp_request_ip     = '0;
        arp_response_ready = 1'b0;
        cache_write_valid  = 1'b0;
        cache_write_ip     = '0;
        cache_write_mac    = '0;
        cache_clear        = 1'b0;
        local_ip           = 32'hC0A8_0180;
        subnet_mask        = 32'hFFFF_FF00;
        gateway_ip         = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(arp_request_ready), 64'd1);
        check("rst_resp_valid", 64'(arp_response_valid), 64'd0);
        check("rst_resp_error", 64'(arp_response_error), 64'd0);
        check("rst_resp_mac", 64'(arp_response_mac), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Learn, then hit
        do_write(32'hC0A8_0166, 48'h5A51_5253_5455);
        do_request(32'hC0A8_0166, 0, 1'b0, 32'h0, 48'h0);

        // Broadcast and miss
        do_request(32'hFFFF_FFFF, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_01FF, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0107, 0, 1'b0, 32'h0, 48'h0);

        // Gateway routing
        do_write(32'hC0A8_0101, 48'h0200_0000_0001);
        gateway_ip = 32'hC0A8_0101;
        do_request(32'h0808_0808, 0, 1'b0, 32'h0, 48'h0);
        gateway_ip = 32'h0;
        do_request(32'h0808_0808, 0, 1'b0, 32'h0, 48'h0);

        // Replacement and in-place update
        do_clear(1'b0, 32'h0);
        for (int i = 0; i < 9; i++) do_write(32'hC0A8_0110 + 32'(i), 48'hA000_0000_0000 + 48'(i));
        do_request(32'hC0A8_0110, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0118, 0, 1'b0, 32'h0, 48'h0);
        do_write(32'hC0A8_0114, 48'hBEEF_0000_0005);
        do_request(32'hC0A8_0114, 0, 1'b0, 32'h0, 48'h0);
        do_write(32'hC0A8_0130, 48'hC000_0000_0030);
        do_request(32'hC0A8_0111, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0112, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0130, 0, 1'b0, 32'h0, 48'h0);

        // Backpressure and write/lookup collision
        do_request(32'hC0A8_0114, 5, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0140, 0, 1'b1, 32'hC0A8_0140, 48'hD000_0000_0040);
        do_request(32'hC0A8_0140, 0, 1'b0, 32'h0, 48'h0);

        // Clear wins over a same-cycle write
        do_clear(1'b1, 32'hC0A8_0150);
        do_request(32'hC0A8_0150, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0140, 0, 1'b0, 32'h0, 48'h0);
        do_request(32'hC0A8_0112, 0, 1'b0, 32'h0, 48'h0);

        // Reset while a response is pending
        do_write(32'hC0A8_0160, 48'hE000_0000_0060);
        @(negedge clk);
        arp_request_valid = 1'b1;
        arp_request_ip    = 32'hC0A8_0160;
        @(posedge clk); #1;
        arp_request_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", 64'(arp_response_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_resp_drop", 64'(arp_response_valid), 64'd0);
        check("rst_req_ready_back", 64'(arp_request_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_request(32'hC0A8_0160, 0, 1'b0, 32'h0, 48'h0);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0)
                gateway_ip = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hC0A8_0121;
            if (op <= 3) begin
                ip  = 32'hC0A8_0120 + 32'($urandom_range(0, 11));
                if ($urandom_range(0, 7) == 0) ip = 32'h0;
                r64 = {$urandom, $urandom};
                do_write(ip, r64[47:0]);
            end else if (op == 9) begin
                do_clear($urandom_range(0, 1) == 1, 32'hC0A8_0120 + 32'($urandom_range(0, 11)));
            end else begin
                case ($urandom_range(0, 5))
                    0:       ip = 32'hFFFF_FFFF;
                    1:       ip = 32'hC0A8_01FF;
                    2:       ip = 32'h0A00_0000 | 32'($urandom_range(0, 255));
                    default: ip = 32'hC0A8_0120 + 32'($urandom_range(0, 11));
                endcase
                r64 = {$urandom, $urandom};
                do_request(ip, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0,
                           32'hC0A8_0120 + 32'($urandom_range(0, 11)), r64[47:0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
